// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC priority path: FSM states, level index,
// spurious vector and the fixed request-line count.
package pic_pkg;

  localparam int NUM_IR = 8;

  typedef logic [2:0] level_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK1 = 1'b1
  } state_t;

  localparam level_t SPURIOUS_ID = 3'd7;

  // Distance from the priority base; 0 is the highest priority.
  function automatic level_t rank(level_t lvl, level_t base);
    return level_t'(lvl - base);
  endfunction

endpackage

// File: rtl/prio_rotate_encoder.sv
// Rotating priority encoder: returns the set request bit closest (circularly)
// to i_base, with a valid flag when any request bit is set.
module prio_rotate_encoder
  import pic_pkg::*;
(
  input  logic [7:0] i_req,
  input  logic [2:0] i_base,
  output logic       o_valid,
  output logic [2:0] o_idx
);

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    // Walk from lowest to highest priority so the last hit is the winner.
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (i_req[level_t'(i_base + 3'(i))]) o_idx = level_t'(i_base + 3'(i));
    end
  end

endmodule

// File: rtl/irq_priority_unit.sv
// IRR/ISR/priority stage of the PIC: synchronises IR lines, resolves priority,
// runs the two-pulse INTA acknowledge and EOI. Optional macro PRI_ROTATE_EN adds rotation.
module irq_priority_unit
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir,
  input  logic       ltim,
  input  logic [7:0] imr,
  input  logic       aeoi,
  input  logic       inta_pulse,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
`ifdef PRI_ROTATE_EN
  input  logic       rotate,
`endif
  output logic       int_req,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic [2:0] vector_id,
  output logic       ack_busy
);

  logic [7:0] r_sync [SYNC_STAGES];
  logic [7:0] r_ir_prev;
  logic [7:0] r_irr;
  logic [7:0] r_isr;
  level_t     r_vector_id;
  logic       r_int_req;
  logic       r_ack_busy;
  logic       r_spurious;
  state_t     r_state;

  level_t     w_base;
  logic [7:0] w_ir_s;
  logic       w_cand_vld;
  level_t     w_cand;
  logic       w_isr_vld;
  level_t     w_isr_top;
  logic       w_eoi_do;
  level_t     w_eoi_lvl;
  logic [7:0] w_isr_eoi;
  logic       w_cand_ok;
  logic       w_ack;
  logic       w_aeoi_clr;
  logic [7:0] w_cand_mask;
  logic [7:0] w_vid_mask;
  logic [7:0] w_irr_set;
  logic [7:0] w_irr_next;
  logic [7:0] w_isr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_ir_prev <= '0;
    end else begin
      r_sync[0] <= ir;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_ir_prev <= w_ir_s;
    end
  end

  assign w_ir_s = r_sync[SYNC_STAGES-1];

`ifdef PRI_ROTATE_EN
  level_t r_base;
  assign w_base = r_base;
`else
  assign w_base = '0;
`endif

  prio_rotate_encoder u_cand_enc (
    .i_req   (r_irr & ~imr),
    .i_base  (w_base),
    .o_valid (w_cand_vld),
    .o_idx   (w_cand)
  );

  prio_rotate_encoder u_isr_enc (
    .i_req   (r_isr),
    .i_base  (w_base),
    .o_valid (w_isr_vld),
    .o_idx   (w_isr_top)
  );

  // EOI is applied before the acknowledge so a same-cycle INTA sees the cleared ISR.
  always_comb begin
    w_eoi_do  = eoi_valid && w_isr_vld;
    w_eoi_lvl = eoi_specific ? eoi_level : w_isr_top;
    w_isr_eoi = r_isr;
    if (w_eoi_do) w_isr_eoi[w_eoi_lvl] = 1'b0;

    w_cand_ok = w_cand_vld;
    for (int j = 0; j < NUM_IR; j++) begin
      if (w_isr_eoi[j] && (rank(3'(j), w_base) <= rank(w_cand, w_base))) w_cand_ok = 1'b0;
    end

    w_ack       = (r_state == ST_IDLE) && inta_pulse && w_cand_ok;
    w_aeoi_clr  = (r_state == ST_ACK1) && inta_pulse && aeoi && !r_spurious;
    w_cand_mask = 8'b1 << w_cand;
    w_vid_mask  = 8'b1 << r_vector_id;

    w_irr_set  = ltim ? w_ir_s : (r_irr | (w_ir_s & ~r_ir_prev));
    w_irr_next = w_ack ? (w_irr_set & ~w_cand_mask) : w_irr_set;
    w_isr_next = w_ack ? (w_isr_eoi | w_cand_mask) : w_isr_eoi;
    if (w_aeoi_clr) w_isr_next = w_isr_next & ~w_vid_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_irr       <= '0;
      r_isr       <= '0;
      r_vector_id <= '0;
      r_int_req   <= 1'b0;
      r_ack_busy  <= 1'b0;
      r_spurious  <= 1'b0;
    end else begin
      r_irr <= w_irr_next;
      r_isr <= w_isr_next;
      case (r_state)
        ST_IDLE: begin
          if (inta_pulse) begin
            r_state     <= ST_ACK1;
            r_ack_busy  <= 1'b1;
            r_int_req   <= 1'b0;
            r_vector_id <= w_cand_ok ? w_cand : SPURIOUS_ID;
            r_spurious  <= !w_cand_ok;
          end else begin
            r_int_req <= w_cand_ok;
          end
        end
        ST_ACK1: begin
          r_int_req <= 1'b0;
          if (inta_pulse) begin
            r_state    <= ST_IDLE;
            r_ack_busy <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PRI_ROTATE_EN
  // An AEOI rotation on the second INTA takes precedence over a same-cycle EOI rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
    end else if (w_aeoi_clr && rotate) begin
      r_base <= level_t'(r_vector_id + 3'd1);
    end else if (w_eoi_do && rotate) begin
      r_base <= level_t'(w_eoi_lvl + 3'd1);
    end
  end
`endif

  assign int_req   = r_int_req;
  assign irr       = r_irr;
  assign isr       = r_isr;
  assign vector_id = r_vector_id;
  assign ack_busy  = r_ack_busy;

endmodule

// File: tb/tb_irq_priority_unit.sv
// Randomised bench for irq_priority_unit: a per-cycle reference model pushes expected
// outputs into a queue that a monitor pops one cycle later and compares.
module tb_irq_priority_unit;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ir = '0;
  logic       ltim = 1'b0;
  logic [7:0] imr = '0;
  logic       aeoi = 1'b0;
  logic       inta_pulse = 1'b0;
  logic       eoi_valid = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = '0;
  logic       rotate = 1'b0;
  logic       int_req;
  logic [7:0] irr;
  logic [7:0] isr;
  logic [2:0] vector_id;
  logic       ack_busy;

  irq_priority_unit #(.SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ir           (ir),
    .ltim         (ltim),
    .imr          (imr),
    .aeoi         (aeoi),
    .inta_pulse   (inta_pulse),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
`ifdef PRI_ROTATE_EN
    .rotate       (rotate),
`endif
    .int_req      (int_req),
    .irr          (irr),
    .isr          (isr),
    .vector_id    (vector_id),
    .ack_busy     (ack_busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [7:0] m_irr, m_isr;
  int       m_base, m_vid;
  bit       m_int, m_busy, m_spur;
  bit [7:0] hist [SYNC+2];

  logic [20:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic int pri_of(int lvl);
    return (lvl - m_base + 8) % 8;
  endfunction

  function automatic int top_level(bit [7:0] v);
    for (int r = 0; r < 8; r++) begin
      if (v[(m_base + r) % 8]) return (m_base + r) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_irr = '0; m_isr = '0; m_base = 0; m_vid = 0;
    m_int = 0; m_busy = 0; m_spur = 0;
    for (int i = 0; i < SYNC + 2; i++) hist[i] = '0;
  endtask

  task automatic model_step();
    bit [7:0] s, p, irr_n, isr_n;
    int lvl, c, base_n;
    bit ok;
    for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ir;
    s = hist[SYNC];
    p = hist[SYNC+1];
    irr_n = ltim ? s : (m_irr | (s & ~p));
    isr_n = m_isr;
    base_n = m_base;
    if (eoi_valid && m_isr != 0) begin
      lvl = eoi_specific ? int'(eoi_level) : top_level(m_isr);
      isr_n[lvl] = 1'b0;
`ifdef PRI_ROTATE_EN
      if (rotate) base_n = (lvl + 1) % 8;
`endif
    end
    c = top_level(m_irr & ~imr);
    ok = (c >= 0);
    for (int j = 0; j < 8; j++) begin
      if (ok && isr_n[j] && pri_of(j) <= pri_of(c)) ok = 0;
    end
    if (!m_busy) begin
      if (inta_pulse) begin
        if (ok) begin
          isr_n[c] = 1'b1;
          irr_n[c] = 1'b0;
          m_vid = c;
          m_spur = 0;
        end else begin
          m_vid = 7;
          m_spur = 1;
        end
        m_busy = 1;
        m_int = 0;
      end else begin
        m_int = ok;
      end
    end else begin
      m_int = 0;
      if (inta_pulse) begin
        m_busy = 0;
        if (aeoi && !m_spur) begin
          isr_n[m_vid] = 1'b0;
`ifdef PRI_ROTATE_EN
          if (rotate) base_n = (m_vid + 1) % 8;
`endif
        end
      end
    end
    m_irr = irr_n;
    m_isr = isr_n;
    m_base = base_n;
    exp_q.push_back({m_int, m_irr, m_isr, 3'(m_vid), m_busy});
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  always @(posedge clk) begin
    logic [20:0] e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("int_req",   32'(int_req),   32'(e[20]));
      chk("irr",       32'(irr),       32'(e[19:12]));
      chk("isr",       32'(isr),       32'(e[11:4]));
      chk("vector_id", 32'(vector_id), 32'(e[3:1]));
      chk("ack_busy",  32'(ack_busy),  32'(e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    inta_pulse = 1'b0;
    eoi_valid = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_ir(logic [7:0] v);
    ir = v; tick(); tick(); ir = '0;
  endtask

  task automatic inta();
    inta_pulse = 1'b1; tick();
  endtask

  task automatic eoi(logic spec, logic [2:0] lvl, logic rot);
    eoi_valid = 1'b1; eoi_specific = spec; eoi_level = lvl; rotate = rot;
    tick();
    rotate = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_int_req",   32'(int_req),   32'd0);
    chk("rst_irr",       32'(irr),       32'd0);
    chk("rst_isr",       32'(isr),       32'd0);
    chk("rst_vector_id", 32'(vector_id), 32'd0);
    chk("rst_ack_busy",  32'(ack_busy),  32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ir = '0; inta_pulse = 1'b0; eoi_valid = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Edge mode single request, acknowledge, non-specific EOI
    pulse_ir(8'h08); idle(4);
    inta(); idle(1); inta(); idle(2);
    eoi(1'b0, 3'd0, 1'b0); idle(2);

    // Nesting: IR2 in service blocks IR5 but not IR0
    pulse_ir(8'h04); idle(4); inta(); inta(); idle(2);
    pulse_ir(8'h20); idle(5);
    pulse_ir(8'h01); idle(4); inta(); inta(); idle(2);
    eoi(1'b0, 3'd0, 1'b0); idle(1);
    eoi(1'b0, 3'd0, 1'b0); idle(4);
    inta(); inta(); eoi(1'b1, 3'd5, 1'b0); idle(2);

    // Masking in level mode
    ltim = 1'b1; imr = 8'h10; ir = 8'h10; idle(6);
    imr = 8'h00; idle(3);
    inta(); inta(); ir = '0; eoi(1'b0, 3'd0, 1'b0); idle(4);

    // Spurious acknowledge
    inta(); idle(2); inta(); idle(2);

    // AEOI with level request still asserted
    aeoi = 1'b1; ir = 8'h40; idle(5);
    inta(); idle(1); inta(); idle(3);
    ir = '0; idle(5); aeoi = 1'b0; ltim = 1'b0;

    // Rotation: service IR0 with rotating EOI, then IR0 and IR1 together
    pulse_ir(8'h01); idle(4); inta(); inta();
    eoi(1'b0, 3'd0, 1'b1); idle(2);
    pulse_ir(8'h03); idle(4); inta(); inta(); idle(1);
    eoi(1'b0, 3'd0, 1'b0); idle(2);
    inta(); inta(); eoi(1'b0, 3'd0, 1'b0); idle(2);

    // Same-cycle EOI and INTA
    pulse_ir(8'h02); idle(4); inta(); inta(); idle(1);
    pulse_ir(8'h02); idle(4);
    eoi_valid = 1'b1; eoi_specific = 1'b0; inta(); inta(); idle(2);
    eoi(1'b0, 3'd0, 1'b0); idle(2);

    // Reset in the middle of an acknowledge
    pulse_ir(8'h80); idle(4); inta(); idle(1);
    do_reset();
    idle(4);

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      if (n % 400 == 0) begin
        ltim = 1'($urandom_range(0, 1));
        aeoi = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) ir = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) imr = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      inta_pulse = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) begin
        eoi_valid = 1'b1;
        eoi_specific = 1'($urandom_range(0, 1));
        eoi_level = 3'($urandom_range(0, 7));
      end
      rotate = 1'($urandom_range(0, 1));
      tick();
    end
    rotate = 1'b0; ir = '0; imr = '0;
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
